// File: rtl/pcie_dll_rx_seq_ack_if.sv
// Bundles the DLL receive TLP input, the forwarded TL TLP output and the
// ACK/NAK DLLP handshake towards the TX arbiter into one port.
interface pcie_dll_rx_seq_ack_if;
    logic         dll_tlp_valid;
    logic [267:0] dll_tlp_data;
    logic         dll_tlp_lcrc_err;
    logic         tl_tlp_valid;
    logic [223:0] tl_tlp_data;
    logic         dllp_valid;
    logic [47:0]  dllp_data;
    logic         dllp_ready;

    modport slave (
        input  dll_tlp_valid,
        input  dll_tlp_data,
        input  dll_tlp_lcrc_err,
        input  dllp_ready,
        output tl_tlp_valid,
        output tl_tlp_data,
        output dllp_valid,
        output dllp_data
    );

    modport master (
        output dll_tlp_valid,
        output dll_tlp_data,
        output dll_tlp_lcrc_err,
        output dllp_ready,
        input  tl_tlp_valid,
        input  tl_tlp_data,
        input  dllp_valid,
        input  dllp_data
    );
endinterface

// File: rtl/pcie_dll_rx_seq_ack.sv
// DLL receive stage: checks TLP sequence numbers, forwards in-order TLPs to
// the Transaction Layer and schedules/issues ACK and NAK DLLPs.
module pcie_dll_rx_seq_ack #(
    parameter int ACK_LATENCY = 64,
    parameter int ACK_TIMER_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pcie_dll_rx_seq_ack_if.slave  bus,
    output logic [11:0]           next_rcv_seq,
    output logic                  nak_scheduled
);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    localparam logic [ACK_TIMER_W-1:0] TIMER_LAST = ACK_TIMER_W'(ACK_LATENCY - 1);

    state_t                 state;
    state_t                 state_next;
    logic [11:0]            seq;
    logic [11:0]            seq_gap;
    logic                   tlp_good;
    logic                   in_order;
    logic                   duplicate;
    logic                   tlp_bad;
    logic                   new_nak;
    logic                   nak_req;
    logic                   ack_req;
    logic                   ack_pending;
    logic [ACK_TIMER_W-1:0] timer;
    logic                   timer_fire;
    logic                   load_nak;
    logic                   load_ack;
    logic                   clear_ack;
    logic [31:0]            dllp_body;
    logic [47:0]            dllp_word;
    logic                   unused_lcrc;

    function automatic logic [15:0] dllp_crc(input logic [31:0] d);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 31; i >= 0; i--) begin
            if (c[15] ^ d[i]) begin
                c = {c[14:0], 1'b0} ^ 16'h100B;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return ~c;
    endfunction

    // The LCRC itself was already checked upstream; only its error flag matters here.
    assign unused_lcrc = ^bus.dll_tlp_data[31:0];

    // Duplicates lie up to 2048 behind NEXT_RCV_SEQ; anything else ahead is a lost TLP.
    assign seq        = bus.dll_tlp_data[267:256];
    assign seq_gap    = next_rcv_seq - seq;
    assign tlp_good   = bus.dll_tlp_valid && !bus.dll_tlp_lcrc_err;
    assign in_order   = tlp_good && (seq == next_rcv_seq);
    assign duplicate  = tlp_good && (seq_gap != 12'd0) && (seq_gap <= 12'd2048);
    assign tlp_bad    = bus.dll_tlp_valid && !in_order && !duplicate;
    assign new_nak    = tlp_bad && !nak_scheduled;
    assign timer_fire = ack_pending && (state == IDLE) && (timer == TIMER_LAST);

    assign dllp_body  = {(load_nak ? 8'h10 : 8'h00), 12'h000, next_rcv_seq - 12'd1};
    assign dllp_word  = {dllp_crc(dllp_body), dllp_body};
    assign clear_ack  = load_nak || timer_fire;

    assign bus.dllp_valid = (state == SEND);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Requests raised in the same cycle go straight out when idle; NAK wins.
    always_comb begin
        state_next = state;
        load_nak   = 1'b0;
        load_ack   = 1'b0;
        case (state)
            IDLE: begin
                if (nak_req || new_nak) begin
                    load_nak   = 1'b1;
                    state_next = SEND;
                end else if (ack_req || duplicate || timer_fire) begin
                    load_ack   = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (bus.dllp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            next_rcv_seq  <= 12'd0;
            nak_scheduled <= 1'b0;
        end else if (in_order) begin
            next_rcv_seq  <= next_rcv_seq + 12'd1;
            nak_scheduled <= 1'b0;
        end else if (tlp_bad) begin
            nak_scheduled <= 1'b1;
        end
    end

    // Requests arriving while a DLLP is in flight wait here for the return to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nak_req <= 1'b0;
            ack_req <= 1'b0;
        end else if (load_nak || load_ack) begin
            nak_req <= 1'b0;
            ack_req <= 1'b0;
        end else if (state == SEND) begin
            nak_req <= nak_req || new_nak;
            ack_req <= ack_req || duplicate;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_pending <= 1'b0;
            timer       <= '0;
        end else begin
            if (clear_ack) begin
                ack_pending <= 1'b0;
                timer       <= '0;
            end else if (ack_pending && (state == IDLE)) begin
                timer <= timer + 1'b1;
            end
            if (in_order) begin
                ack_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.tl_tlp_valid <= 1'b0;
            bus.tl_tlp_data  <= '0;
            bus.dllp_data    <= '0;
        end else begin
            bus.tl_tlp_valid <= in_order;
            if (in_order) begin
                bus.tl_tlp_data <= bus.dll_tlp_data[255:32];
            end
            if (load_nak || load_ack) begin
                bus.dllp_data <= dllp_word;
            end
        end
    end

endmodule

// File: doc/pcie_dll_rx_seq_ack.md
Name: pcie_dll_rx_seq_ack

Overview:
Data Link Layer receive stage sitting between the LCRC/framing front end and the Transaction Layer. It checks the sequence number of each received DLL TLP and forwards good, in-order TLPs (224-bit TL TLP) to the TL. It schedules ACK/NAK and emits the ACK/NAK DLLP (48-bit dllp_packet, CRC-16 included) to the DLL TX arbiter.

Parameters:
ACK_LATENCY, 64, cycles from the first unacknowledged good TLP to ACK DLLP issue (1..255).
ACK_TIMER_W, 8, width of the ACK latency counter.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
dll_tlp_valid  in  1  one-cycle strobe, DLL TLP present
dll_tlp_data  in  268  [267:256] seq_num, [255:32] TL TLP, [31:0] LCRC
dll_tlp_lcrc_err  in  1  LCRC/framing error for this TLP, qualified by valid
tl_tlp_valid  out  1  forwarded TLP strobe; no backpressure
tl_tlp_data  out  224  forwarded TL TLP
dllp_valid  out  1  ACK/NAK DLLP valid
dllp_data  out  48  dllp_packet: crc1, ack_or_nak, reserved, seq_num
dllp_ready  in  1  TX arbiter accepts when valid && ready
next_rcv_seq  out  12  NEXT_RCV_SEQ
nak_scheduled  out  1  NAK_SCHEDULED flag

Behaviour:
- Reset (async assert, sync release): all outputs 0; next_rcv_seq=0; nak_scheduled=0; ack_pending=0; timer=0; FSM=IDLE.
- seq = dll_tlp_data[267:256]. Classification is evaluated only when dll_tlp_valid=1.
  - LCRC error: drop. If !nak_scheduled, raise nak_req and set nak_scheduled. Otherwise, no action.
  - Good, seq==next_rcv_seq: register dll_tlp_data[255:32] to tl_tlp_data with tl_tlp_valid=1 the next cycle (latency 1, single-cycle pulse). Increment next_rcv_seq mod 4096. Clear nak_scheduled. Set ack_pending.
  - Good duplicate, (next_rcv_seq - seq) mod 4096 in 1..2048: drop. Raise ack_req immediately, without waiting for the timer.
  - Good, otherwise (future seq): drop. Treat as LCRC error for NAK scheduling.
- ACK timer: counts while ack_pending and FSM==IDLE. On reaching ACK_LATENCY-1, raise ack_req and clear timer/ack_pending. A new good TLP does not restart a running timer.
- FSM IDLE to SEND: taken when nak_req or ack_req is pending. NAK has priority; a lower-priority ACK request is discarded when a NAK is sent. On entry, latch dllp_data:
  - ack_or_nak = 0x00 for ACK, 0x10 for NAK.
  - reserved = 0.
  - seq_num = next_rcv_seq - 1 mod 4096, using the value at latch time.
  - crc1 = CRC-16, poly 0x100B, seed 0xFFFF, over bits [31:0] processed MSB first, final result inverted.
- FSM SEND: dllp_valid=1. dllp_data is held stable until dllp_ready=1, then returns to IDLE with dllp_valid=0 the next cycle. Requests arriving during SEND stay pending. If a NAK arrives while an ACK is in SEND, the ACK completes, then the NAK is issued. Sending a NAK clears ack_pending and the timer, since the NAK acknowledges through seq_num.
- Simultaneous TLP arrival and SEND handshake: the TLP update is applied first for next_rcv_seq. The in-flight latched DLLP is unchanged.
- Wrap: next_rcv_seq 4095 to 0; ACK seq_num after reset with no TLPs = 0xFFF.
- Reset mid-SEND: dllp_valid drops asynchronously; the pending DLLP is lost.

Test Plan:
- Good seq 0,1,2 back to back, lcrc_err=0 -> tl_tlp_valid pulses 1 cycle after each with matching payload; next_rcv_seq=3; ACK_LATENCY cycles after seq 0 -> dllp_data ack_or_nak=0x00, seq_num=2, crc1 matches model.
- After reset, TLP seq 0 with lcrc_err=1 -> no TL output; NAK seq_num=0xFFF; nak_scheduled=1; second erroneous TLP -> no second NAK; then good seq 0 -> forwarded, nak_scheduled=0.
- Accept seq 0..4, then resend seq 3 -> dropped, no TL output; ACK seq_num=4 issued within 2 cycles, without waiting for the timer.
- Force next_rcv_seq=4095 via 4095 good TLPs (or backdoor), then send seq 4095 -> forwarded, next_rcv_seq=0, ACK seq_num=4095.
- Future seq 7 when expecting 5 -> dropped, NAK seq_num=4; dllp_ready held low 10 cycles -> dllp_valid/data stable throughout, single transfer on ready.
- Assert rst_n low during SEND with dllp_ready=0 -> dllp_valid=0 immediately; after release, next_rcv_seq=0 and no DLLP until new events.
